// File: rtl/sram_slot_arbiter.sv
// sram_slot_arbiter
//   Shares one external SRAM/ROM port between the CPU load/store path and the
//   VGA fetcher. A free-running 3-bit slot counter defines an 8-slot frame.
//   VGA has priority in slots 0..VGA_SLOTS-1. Outside that window the CPU has
//   priority. Arbitration is work-conserving: an idle port is always handed to
//   any requester.
//   Each access is IDLE -> ACCESS (ACC_CYC cycles) -> RELEASE (1 cycle).
//   All outputs are registered.
//
//   Optional feature macro: STARVE_GUARD_EN.
//     When it is defined, a counter tracks the VGA grants made while the CPU
//     is waiting. At STARVE_MAX, the CPU wins the next arbitration even inside
//     the VGA window.
//
// Handshake (both requesters):
//   - req is held until the matching ack.
//   - gnt pulses for one cycle in the first ACCESS cycle.
//   - ack pulses in the RELEASE cycle. rdata is valid while ack is high.
//   - A req still high after the edge that ends the ack cycle is a new request.
//   - Address, we and wdata are sampled on the grant edge only.
//
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   cpu_req/we/addr/wdata            CPU request inputs
//   cpu_gnt/ack/rdata                CPU responses
//   vga_req/addr                     VGA read request inputs
//   vga_gnt/ack/rdata                VGA responses
//   sram_ce_n/oe_n/we_n              active-low memory strobes
//   sram_addr/dout                   latched address / write data
//   sram_din                         data returned from memory
//   slot                             free-running slot counter
module sram_slot_arbiter #(
   parameter int DW         = 16,
   parameter int AW         = 16,
   parameter int ACC_CYC    = 2,
   parameter int VGA_SLOTS  = 4,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          vga_req,
   input  logic [AW-1:0] vga_addr,
   output logic          vga_gnt,
   output logic          vga_ack,
   output logic [DW-1:0] vga_rdata,
   output logic          sram_ce_n,
   output logic          sram_oe_n,
   output logic          sram_we_n,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_dout,
   input  logic [DW-1:0] sram_din,
   output logic [2:0]    slot
);

   typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

   localparam int            CW       = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
   localparam logic [CW-1:0] LAST_CYC = CW'(ACC_CYC - 1);
   localparam logic [3:0]    WIN_LIM  = 4'(VGA_SLOTS);

   state_t        state, state_nx;
   logic [CW-1:0] cyc, cyc_nx;
   logic          own_vga, own_vga_nx;
   logic          wr, wr_nx;
   logic [AW-1:0] addr_nx;
   logic [DW-1:0] dout_nx, cpu_rdata_nx, vga_rdata_nx;
   logic          ce_nx, oe_nx, we_nx;
   logic          cpu_gnt_nx, vga_gnt_nx, cpu_ack_nx, vga_ack_nx;

   logic in_window, force_cpu, vga_first, pick_vga, pick_cpu;

   // VGA wins inside its window unless the starvation guard forces the CPU.
   // Outside the window, VGA is served only when the CPU is not asking.
   assign in_window = ({1'b0, slot} < WIN_LIM);
   assign vga_first = vga_req && in_window && !force_cpu;
   assign pick_vga  = vga_first || (vga_req && !cpu_req);
   assign pick_cpu  = cpu_req && !vga_first;

`ifdef STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_MAX + 1);
   logic [SW-1:0] starve_cnt;

   assign force_cpu = cpu_req && (starve_cnt == SW'(STARVE_MAX));

   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (state == IDLE) begin
         if (pick_cpu)
            starve_cnt <= '0;
         else if (pick_vga && cpu_req && (starve_cnt != SW'(STARVE_MAX)))
            starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   assign force_cpu = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cyc       <= '0;
         own_vga   <= 1'b0;
         wr        <= 1'b0;
         slot      <= 3'd0;
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
         sram_addr <= '0;
         sram_dout <= '0;
         cpu_rdata <= '0;
         vga_rdata <= '0;
         cpu_gnt   <= 1'b0;
         vga_gnt   <= 1'b0;
         cpu_ack   <= 1'b0;
         vga_ack   <= 1'b0;
      end else begin
         state     <= state_nx;
         cyc       <= cyc_nx;
         own_vga   <= own_vga_nx;
         wr        <= wr_nx;
         slot      <= slot + 3'd1;
         sram_ce_n <= ce_nx;
         sram_oe_n <= oe_nx;
         sram_we_n <= we_nx;
         sram_addr <= addr_nx;
         sram_dout <= dout_nx;
         cpu_rdata <= cpu_rdata_nx;
         vga_rdata <= vga_rdata_nx;
         cpu_gnt   <= cpu_gnt_nx;
         vga_gnt   <= vga_gnt_nx;
         cpu_ack   <= cpu_ack_nx;
         vga_ack   <= vga_ack_nx;
      end
   end

   // Strobe values are computed one cycle ahead, so the registered strobes
   // line up with the state they belong to.
   always_comb begin
      state_nx     = state;
      cyc_nx       = cyc;
      own_vga_nx   = own_vga;
      wr_nx        = wr;
      addr_nx      = sram_addr;
      dout_nx      = sram_dout;
      cpu_rdata_nx = cpu_rdata;
      vga_rdata_nx = vga_rdata;
      ce_nx        = 1'b1;
      oe_nx        = 1'b1;
      we_nx        = 1'b1;
      cpu_gnt_nx   = 1'b0;
      vga_gnt_nx   = 1'b0;
      cpu_ack_nx   = 1'b0;
      vga_ack_nx   = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_vga || pick_cpu) begin
               state_nx   = ACCESS;
               cyc_nx     = '0;
               own_vga_nx = pick_vga;
               wr_nx      = pick_cpu && cpu_we;
               addr_nx    = pick_vga ? vga_addr : cpu_addr;
               if (pick_cpu)
                  dout_nx = cpu_wdata;
               cpu_gnt_nx = pick_cpu;
               vga_gnt_nx = pick_vga;
               ce_nx      = 1'b0;
               oe_nx      = wr_nx;
               // The first write cycle sets up the address with we_n high.
               // A single-cycle access must strobe immediately.
               we_nx      = !(wr_nx && (ACC_CYC == 1));
            end
         end
         ACCESS: begin
            if (cyc == LAST_CYC) begin
               state_nx = RELEASE;
               if (!wr) begin
                  if (own_vga)
                     vga_rdata_nx = sram_din;
                  else
                     cpu_rdata_nx = sram_din;
               end
               cpu_ack_nx = !own_vga;
               vga_ack_nx = own_vga;
            end else begin
               cyc_nx = cyc + 1'b1;
               ce_nx  = 1'b0;
               oe_nx  = wr;
               we_nx  = !wr;
            end
         end
         RELEASE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// tb_sram_slot_arbiter
//   Bench for sram_slot_arbiter.
//   - Driver tasks issue CPU and VGA transactions and push the expected
//     response into per-requester queues.
//   - A negedge monitor tracks slot, arbitration and access timing from the
//     arbitration rules and checks every DUT output against them.
//   - A small SRAM model answers reads and absorbs writes.
//   - Honours STARVE_GUARD_EN the same way as the design.
module tb_sram_slot_arbiter;

   localparam int ACC = 2;
   localparam int VS  = 4;
   localparam int SM  = 4;
`ifdef STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk, rst;
   logic        cpu_req, cpu_we, cpu_gnt, cpu_ack;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        vga_req, vga_gnt, vga_ack;
   logic [15:0] vga_addr, vga_rdata;
   logic        sram_ce_n, sram_oe_n, sram_we_n;
   logic [15:0] sram_addr, sram_dout, sram_din;
   logic [2:0]  slot;

   int total = 0;
   int bad   = 0;

   logic [32:0] cpu_exp_q[$];
   logic [32:0] vga_exp_q[$];
   bit          gnt_log[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   sram_slot_arbiter #(.DW(16), .AW(16), .ACC_CYC(ACC), .VGA_SLOTS(VS), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .vga_req(vga_req), .vga_addr(vga_addr),
      .vga_gnt(vga_gnt), .vga_ack(vga_ack), .vga_rdata(vga_rdata),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
      .slot(slot)
   );

   // ---------------- memory model ----------------
   // CPU addresses live in 0x00xx and VGA addresses in 0x80xx, so VGA reads
   // never race with CPU writes.
   function automatic logic [8:0] idx(input logic [15:0] a);
      return {a[15], a[7:0]};
   endfunction

   function automatic logic [15:0] init_val(input int i);
      if (i == 16) return 16'hBEEF;
      return 16'(i * 97 + 3);
   endfunction

   logic [15:0] phys_mem [0:511];
   logic [15:0] ref_mem  [0:511];
   bit          mem_ready;

   assign sram_din = phys_mem[idx(sram_addr)];

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 512; i++) phys_mem[i] <= init_val(i);
         mem_ready <= 1'b1;
      end else if (sram_ce_n === 1'b0 && sram_we_n === 1'b0) begin
         phys_mem[idx(sram_addr)] <= sram_dout;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic        rst_seen;
   int          m_slot, phase, prev_slot, starve;
   bit          prev_idle, prev_cpu, prev_vga, eg_cpu, eg_vga;
   bit          cur_vga, cur_we;
   logic [15:0] cur_addr, cur_data, last_cpu_rd, last_vga_rd;
   logic [32:0] ent;
   logic [2:0]  exp_str;

   always @(posedge clk) rst_seen <= rst;

   always @(negedge clk) begin
      if (!rst_seen) begin
         chk("reset_ctl", {sram_ce_n, sram_oe_n, sram_we_n, cpu_gnt, vga_gnt, cpu_ack, vga_ack, slot},
             {3'b111, 4'b0000, 3'd0});
         chk("reset_data", {sram_addr, sram_dout, cpu_rdata, vga_rdata}, 64'd0);
         m_slot = 0; phase = 0; starve = 0;
         last_cpu_rd = '0; last_vga_rd = '0;
         cpu_exp_q.delete(); vga_exp_q.delete();
         prev_idle = 1'b1;
      end else begin
         m_slot = (m_slot + 1) % 8;
         chk("slot", 64'(slot), 64'(m_slot));
         // Expected grant from the arbitration rules applied to the idle cycle.
         eg_cpu = 1'b0; eg_vga = 1'b0;
         if (prev_idle && (prev_cpu || prev_vga)) begin
            if (GUARD && prev_cpu && starve == SM) eg_cpu = 1'b1;
            else if (prev_vga && prev_slot < VS)   eg_vga = 1'b1;
            else if (prev_cpu)                     eg_cpu = 1'b1;
            else                                   eg_vga = 1'b1;
         end
         chk("gnt", {cpu_gnt, vga_gnt}, {eg_cpu, eg_vga});
         if (eg_cpu || eg_vga) begin
            gnt_log.push_back(eg_vga);
            if (eg_cpu) starve = 0;
            else if (prev_cpu) starve++;
            phase   = 1;
            cur_vga = eg_vga;
            if ((eg_vga && vga_exp_q.size() == 0) || (eg_cpu && cpu_exp_q.size() == 0)) begin
               total++; bad++;
               $display("FAIL gnt_without_request: got grant expected none (t=%0t)", $time);
               ent = '0;
            end else begin
               ent = eg_vga ? vga_exp_q[0] : cpu_exp_q[0];
            end
            {cur_we, cur_addr, cur_data} = ent;
         end else if (phase == ACC + 1) begin
            phase = 0;
         end else if (phase > 0) begin
            phase++;
         end
         if (phase >= 1 && phase <= ACC) begin
            exp_str = {1'b0, cur_we, (cur_we && !(phase == 1 && ACC > 1)) ? 1'b0 : 1'b1};
            chk("strobes", {sram_ce_n, sram_oe_n, sram_we_n}, exp_str);
            chk("sram_addr", sram_addr, cur_addr);
            if (cur_we) chk("sram_dout", sram_dout, cur_data);
         end else begin
            chk("strobes_idle", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
         end
         if (phase == ACC + 1) begin
            chk("ack", {cpu_ack, vga_ack}, {!cur_vga, cur_vga});
            if (cur_vga && vga_exp_q.size() > 0) void'(vga_exp_q.pop_front());
            if (!cur_vga && cpu_exp_q.size() > 0) void'(cpu_exp_q.pop_front());
            if (!cur_we) begin
               if (cur_vga) last_vga_rd = cur_data;
               else         last_cpu_rd = cur_data;
            end
            chk("cpu_rdata", cpu_rdata, last_cpu_rd);
            chk("vga_rdata", vga_rdata, last_vga_rd);
         end else begin
            chk("ack_idle", {cpu_ack, vga_ack}, 2'b00);
         end
         prev_idle = (phase == 0);
      end
      prev_cpu  = cpu_req;
      prev_vga  = vga_req;
      prev_slot = m_slot;
   end

   // ---------------- drivers ----------------
   // Called at posedge+#1. Returns at posedge+#1 after the ack cycle.
   // keep=1 leaves req high so the caller can chain a new request.
   task automatic cpu_txn(input logic we, input logic [15:0] addr, input logic [15:0] data,
                          input bit keep);
      bit got = 1'b0;
      if (we) ref_mem[idx(addr)] = data;
      cpu_exp_q.push_back({we, addr, we ? data : ref_mem[idx(addr)]});
      cpu_we = we; cpu_addr = addr; cpu_wdata = data; cpu_req = 1'b1;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         if (cpu_ack) got = 1'b1;
         if (cpu_gnt) begin
            #1 cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
         end
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL cpu_ack_timeout: got no ack expected ack (t=%0t)", $time);
      end
      @(posedge clk); #1;
      if (!keep) cpu_req = 1'b0;
   endtask

   task automatic vga_txn(input logic [15:0] addr, input bit keep);
      bit got = 1'b0;
      vga_exp_q.push_back({1'b0, addr, ref_mem[idx(addr)]});
      vga_addr = addr; vga_req = 1'b1;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         if (vga_ack) got = 1'b1;
         if (vga_gnt) begin
            #1 vga_addr = 16'($urandom);
         end
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL vga_ack_timeout: got no ack expected ack (t=%0t)", $time);
      end
      @(posedge clk); #1;
      if (!keep) vga_req = 1'b0;
   endtask

   // Returns at posedge+#1 of the cycle whose slot value is s.
   task automatic align_to(input int s);
      int n = 0;
      do begin
         @(negedge clk); #1; n++;
      end while (m_slot != (s + 7) % 8 && n < 32);
      @(posedge clk); #1;
   endtask

   function automatic logic [15:0] rnd_cpu_addr();
      return {8'h00, 8'($urandom_range(0, 239))};
   endfunction

   function automatic logic [15:0] rnd_vga_addr();
      return {8'h80, 8'($urandom_range(0, 255))};
   endfunction

   // ---------------- stimulus ----------------
   int cpu_cnt;
   bit rs_got;

   initial begin
      for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
      rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      vga_req = 1'b0; vga_addr = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single read returning BEEF, then write 0x1234 to 0x0040 and read back.
      cpu_txn(1'b0, 16'h0010, 16'h0000, 1'b0);
      cpu_txn(1'b1, 16'h0040, 16'h1234, 1'b0);
      cpu_txn(1'b0, 16'h0040, 16'h0000, 1'b0);

      // Simultaneous requests inside and outside the VGA window.
      align_to(1);
      gnt_log.delete();
      fork
         cpu_txn(1'b0, rnd_cpu_addr(), 16'h0, 1'b0);
         vga_txn(rnd_vga_addr(), 1'b0);
      join
      chk("order_slot1", (gnt_log.size() >= 2) ? {gnt_log[0], gnt_log[1]} : 2'b11, 2'b10);
      align_to(5);
      gnt_log.delete();
      fork
         cpu_txn(1'b0, rnd_cpu_addr(), 16'h0, 1'b0);
         vga_txn(rnd_vga_addr(), 1'b0);
      join
      chk("order_slot5", (gnt_log.size() >= 2) ? {gnt_log[0], gnt_log[1]} : 2'b11, 2'b01);

      // VGA held high permanently while the CPU keeps asking.
      gnt_log.delete();
      fork
         begin
            for (int i = 0; i < 14; i++) vga_txn(rnd_vga_addr(), i < 13);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            for (int j = 0; j < 3; j++) cpu_txn(1'($urandom_range(0, 1)), rnd_cpu_addr(),
                                               16'($urandom), 1'b0);
         end
      join
      cpu_cnt = 0;
      foreach (gnt_log[k]) if (!gnt_log[k]) cpu_cnt++;
      chk("starve_cpu_grants", 64'(cpu_cnt), 64'd3);

      // Back-to-back CPU reads with req held.
      for (int i = 0; i < 6; i++) cpu_txn(1'b0, rnd_cpu_addr(), 16'h0, i < 5);

      // Random traffic from both requesters.
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               bit keep = (i < 39) && ($urandom_range(0, 3) == 0);
               cpu_txn(1'($urandom_range(0, 1)), rnd_cpu_addr(), 16'($urandom), keep);
               if (!keep) begin
                  repeat ($urandom_range(0, 5)) @(posedge clk);
                  #1;
               end
            end
         end
         begin
            for (int i = 0; i < 40; i++) begin
               bit keep = (i < 39) && ($urandom_range(0, 2) == 0);
               vga_txn(rnd_vga_addr(), keep);
               if (!keep) begin
                  repeat ($urandom_range(0, 6)) @(posedge clk);
                  #1;
               end
            end
         end
      join

      // Reset in the middle of a CPU write.
      cpu_exp_q.push_back({1'b1, 16'h00F5, 16'hA5A5});
      cpu_we = 1'b1; cpu_addr = 16'h00F5; cpu_wdata = 16'hA5A5; cpu_req = 1'b1;
      rs_got = 1'b0;
      for (int n = 0; n < 50 && !rs_got; n++) begin
         @(negedge clk);
         if (cpu_gnt) rs_got = 1'b1;
      end
      chk("reset_test_gnt", 64'(rs_got), 64'd1);
      #1 rst = 1'b0; cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      // Recovery after reset.
      cpu_txn(1'b0, 16'h0040, 16'h0, 1'b0);
      vga_txn(rnd_vga_addr(), 1'b0);
      cpu_txn(1'b0, 16'h00F5, 16'h0, 1'b0);

      repeat (4) @(posedge clk);
      chk("cpu_q_drained", 64'(cpu_exp_q.size()), 64'd0);
      chk("vga_q_drained", 64'(vga_exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
